// File: rtl/regfile_write_arbiter_pkg.sv
// Shared types and defaults for the register-file write-port arbiter.
// The WB stage and the long-latency unit (LLU) share one write port;
// these definitions are common to the arbiter and its result buffer.
package regfile_write_arbiter_pkg;

  localparam int REGWR_XLEN                 = 32;
  localparam int REGWR_DEPTH_DEFAULT        = 2;
  localparam int REGWR_STARVE_LIMIT_DEFAULT = 4;

  // A pending register write: destination and value
  typedef struct packed {
    logic [4:0]            rd;
    logic [REGWR_XLEN-1:0] data;
  } regwr_req_t;

  // A buffered LLU result; kill marks it as superseded by a younger WB write
  typedef struct packed {
    regwr_req_t req;
    logic       kill;
  } regwr_entry_t;

  // Which requester owns the write port in the current cycle
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_WB   = 2'd1,
    SRC_LLU  = 2'd2
  } regwr_src_e;

  // Source/destination compare that never matches x0
  function automatic logic rd_match(input logic [4:0] src, input logic [4:0] dst);
    return (src != 5'd0) && (src == dst);
  endfunction

endpackage

// File: rtl/regwr_fifo.sv
// Circular buffer of LLU results waiting for an idle register-file write port.
// Each entry carries rd, data and a kill bit; the per-entry valid/rd/kill
// vectors are exposed so the arbiter can run hazard compares on them.
module regwr_fifo
  import regfile_write_arbiter_pkg::*;
#(
  parameter int  XLEN  = REGWR_XLEN,
  parameter int  DEPTH = REGWR_DEPTH_DEFAULT,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push_i,
  input  logic [4:0]            push_rd_i,
  input  logic [XLEN-1:0]       push_data_i,
  input  logic                  pop_i,
  input  logic                  kill_en_i,
  input  logic [4:0]            kill_rd_i,
  output logic [4:0]            head_rd_o,
  output logic [XLEN-1:0]       head_data_o,
  output logic                  head_kill_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic [CNT_W-1:0]      count_o,
  output logic [DEPTH-1:0]      valid_o,
  output logic [DEPTH-1:0][4:0] rd_o,
  output logic [DEPTH-1:0]      kill_o
);

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] kill_q, kill_d;
  logic [4:0]       rd_q   [DEPTH];
  logic [XLEN-1:0]  data_q [DEPTH];
  logic             pushOk;
  logic             popOk;

  // Advance a pointer, wrapping at DEPTH (DEPTH need not be a power of two)
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (int'(p) == DEPTH - 1) begin
      return '0;
    end
    return p + 1'b1;
  endfunction

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;

  // Guard against pushing into a full buffer or popping an empty one
  assign pushOk = push_i & ~full_o;
  assign popOk  = pop_i & ~empty_o;

  assign head_rd_o   = rd_q[head_q];
  assign head_data_o = data_q[head_q];
  assign head_kill_o = kill_q[head_q];
  assign valid_o     = valid_q;
  assign kill_o      = kill_q;

  // Flatten the stored destinations for the arbiter's compare logic
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      rd_o[i] = rd_q[i];
    end
  end

  // Next pointers, occupancy and kill bits; a WB kill also hits the entry pushed this cycle
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    valid_d = valid_q;
    kill_d  = kill_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (kill_en_i && valid_q[i] && (rd_q[i] == kill_rd_i)) begin
        kill_d[i] = 1'b1;
      end
    end
    if (popOk) begin
      valid_d[head_q] = 1'b0;
      kill_d[head_q]  = 1'b0;
      head_d          = ptr_inc(head_q);
    end
    if (pushOk) begin
      valid_d[tail_q] = 1'b1;
      kill_d[tail_q]  = kill_en_i && (push_rd_i == kill_rd_i);
      tail_d          = ptr_inc(tail_q);
    end
    case ({pushOk, popOk})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control state register; reset discards every buffered result
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      kill_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
      kill_q  <= kill_d;
    end
  end

  // Payload storage; only meaningful where valid is set, so it needs no reset
  always_ff @(posedge clk) begin
    if (pushOk) begin
      rd_q[tail_q]   <= push_rd_i;
      data_q[tail_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter. WB always owns the port when it writes;
// LLU results wait in a small buffer and drain when WB is idle. Younger WB
// writes kill stale buffered results, buffered destinations raise RAW hazards,
// and a starved buffer requests an issue stall so WB bubbles free the port.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int  XLEN         = REGWR_XLEN,
  parameter int  DEPTH        = REGWR_DEPTH_DEFAULT,
  parameter int  STARVE_LIMIT = REGWR_STARVE_LIMIT_DEFAULT,
  localparam int CNT_W        = $clog2(DEPTH + 1),
  localparam int STARVE_W     = $clog2(STARVE_LIMIT + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wb_we,
  input  logic [4:0]       wb_rd,
  input  logic [XLEN-1:0]  wb_data,
  input  logic             llu_valid,
  input  logic [4:0]       llu_rd,
  input  logic [XLEN-1:0]  llu_data,
  output logic             llu_ready,
  output logic             reg_write,
  output logic [4:0]       wt_addr,
  output logic [XLEN-1:0]  wt_data,
  input  logic [4:0]       id_rs1_addr,
  input  logic [4:0]       id_rs2_addr,
  output logic             pending_hit,
  output logic             stall_req,
  output logic [CNT_W-1:0] fifo_count
);

  logic                  wbLive;
  logic                  fifoPush;
  logic                  fifoPop;
  logic                  fifoEmpty;
  logic                  fifoFull;
  logic [4:0]            headRd;
  logic [XLEN-1:0]       headData;
  logic                  headKill;
  logic [DEPTH-1:0]      entryValid;
  logic [DEPTH-1:0][4:0] entryRd;
  logic [DEPTH-1:0]      entryKill;
  regwr_src_e            grantSrc;
  logic [STARVE_W-1:0]   starveCount_q, starveCount_d;
  logic                  stallReq_q, stallReq_d;

  // Writes to x0 are architecturally void, so they never claim the port
  assign wbLive = wb_we && (wb_rd != 5'd0);

  // Readiness comes only from the registered occupancy; no push into a full buffer
  assign llu_ready = ~fifoFull;

  // An x0 result is acknowledged to the LLU but never allocated
  assign fifoPush = llu_valid && llu_ready && (llu_rd != 5'd0);

  regwr_fifo #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (fifoPush),
    .push_rd_i   (llu_rd),
    .push_data_i (llu_data),
    .pop_i       (fifoPop),
    .kill_en_i   (wbLive),
    .kill_rd_i   (wb_rd),
    .head_rd_o   (headRd),
    .head_data_o (headData),
    .head_kill_o (headKill),
    .empty_o     (fifoEmpty),
    .full_o      (fifoFull),
    .count_o     (fifo_count),
    .valid_o     (entryValid),
    .rd_o        (entryRd),
    .kill_o      (entryKill)
  );

  // Port owner: live WB first, then the buffer head, else nobody
  always_comb begin
    grantSrc = SRC_NONE;
    if (wbLive) begin
      grantSrc = SRC_WB;
    end else if (!fifoEmpty) begin
      grantSrc = SRC_LLU;
    end
  end

  // Drive the register-file port; a killed head still pops but writes nothing
  always_comb begin
    reg_write = 1'b0;
    wt_addr   = '0;
    wt_data   = '0;
    fifoPop   = 1'b0;
    case (grantSrc)
      SRC_WB: begin
        reg_write = 1'b1;
        wt_addr   = wb_rd;
        wt_data   = wb_data;
      end
      SRC_LLU: begin
        fifoPop   = 1'b1;
        reg_write = ~headKill;
        wt_addr   = headRd;
        wt_data   = headData;
      end
      default: begin
      end
    endcase
  end

  // RAW hazard against any live buffered result or the result arriving now
  always_comb begin
    pending_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entryValid[i] && !entryKill[i] &&
          (rd_match(id_rs1_addr, entryRd[i]) || rd_match(id_rs2_addr, entryRd[i]))) begin
        pending_hit = 1'b1;
      end
    end
    if (llu_valid && (rd_match(id_rs1_addr, llu_rd) || rd_match(id_rs2_addr, llu_rd))) begin
      pending_hit = 1'b1;
    end
  end

  // Count cycles a live head loses the port to WB; stall once the limit is reached
  always_comb begin
    starveCount_d = starveCount_q;
    stallReq_d    = stallReq_q;
    if (fifoEmpty || fifoPop) begin
      starveCount_d = '0;
      stallReq_d    = 1'b0;
    end else begin
      if (!headKill && wbLive && (starveCount_q != STARVE_W'(STARVE_LIMIT))) begin
        starveCount_d = starveCount_q + 1'b1;
      end
      if (starveCount_d == STARVE_W'(STARVE_LIMIT)) begin
        stallReq_d = 1'b1;
      end
    end
  end

  // Starvation state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starveCount_q <= '0;
      stallReq_q    <= 1'b0;
    end else begin
      starveCount_q <= starveCount_d;
      stallReq_q    <= stallReq_d;
    end
  end

  assign stall_req = stallReq_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: a queue of expected buffered
// writes is filled as LLU results are driven and drained as the port frees up.
module tb_regfile_write_arbiter;

  localparam int XLEN  = 32;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             wb_we;
  logic [4:0]       wb_rd;
  logic [XLEN-1:0]  wb_data;
  logic             llu_valid;
  logic [4:0]       llu_rd;
  logic [XLEN-1:0]  llu_data;
  logic             llu_ready;
  logic             reg_write;
  logic [4:0]       wt_addr;
  logic [XLEN-1:0]  wt_data;
  logic [4:0]       id_rs1_addr;
  logic [4:0]       id_rs2_addr;
  logic             pending_hit;
  logic             stall_req;
  logic [1:0]       fifo_count;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    bit          kill;
  } expEntry_t;

  expEntry_t   expQ[$];
  int          starveModel = 0;
  bit          stallModel  = 0;
  int          checks      = 0;
  int          failures    = 0;
  logic [31:0] dutRf [32];

  always #5 clk = ~clk;

  regfile_write_arbiter #(
    .XLEN         (XLEN),
    .DEPTH        (DEPTH),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .wb_we       (wb_we),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .llu_valid   (llu_valid),
    .llu_rd      (llu_rd),
    .llu_data    (llu_data),
    .llu_ready   (llu_ready),
    .reg_write   (reg_write),
    .wt_addr     (wt_addr),
    .wt_data     (wt_data),
    .id_rs1_addr (id_rs1_addr),
    .id_rs2_addr (id_rs2_addr),
    .pending_hit (pending_hit),
    .stall_req   (stall_req),
    .fifo_count  (fifo_count)
  );

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, check outputs at the falling edge, then advance the model
  task automatic applyStimulus(input logic we, input logic [4:0] wrd, input logic [31:0] wdata,
                               input logic lv, input logic [4:0] lrd, input logic [31:0] ldata,
                               input logic [4:0] rs1 = 5'd0, input logic [4:0] rs2 = 5'd0);
    bit          live;
    bit          expWrite;
    bit          expHit;
    bit          popNow;
    bit          accept;
    bit          headKilled;
    int          sizeBefore;
    logic [4:0]  expAddr;
    logic [31:0] expData;
    expEntry_t   e;

    wb_we       = we;
    wb_rd       = wrd;
    wb_data     = wdata;
    llu_valid   = lv;
    llu_rd      = lrd;
    llu_data    = ldata;
    id_rs1_addr = rs1;
    id_rs2_addr = rs2;

    @(negedge clk);
    live       = we && (wrd != 5'd0);
    sizeBefore = expQ.size();
    headKilled = (sizeBefore > 0) ? expQ[0].kill : 1'b0;
    expWrite   = 1'b0;
    expAddr    = '0;
    expData    = '0;
    if (live) begin
      expWrite = 1'b1;
      expAddr  = wrd;
      expData  = wdata;
    end else if (sizeBefore > 0) begin
      expWrite = !expQ[0].kill;
      expAddr  = expQ[0].rd;
      expData  = expQ[0].data;
    end
    expHit = 1'b0;
    foreach (expQ[i]) begin
      if (!expQ[i].kill && expQ[i].rd != 0 &&
          ((rs1 == expQ[i].rd) || (rs2 == expQ[i].rd))) expHit = 1'b1;
    end
    if (lv && lrd != 0 && ((rs1 == lrd) || (rs2 == lrd))) expHit = 1'b1;

    checkOutput("reg_write", reg_write, expWrite);
    if (expWrite) begin
      checkOutput("wt_addr", wt_addr, expAddr);
      checkOutput("wt_data", wt_data, expData);
    end
    checkOutput("llu_ready", llu_ready, sizeBefore < DEPTH);
    checkOutput("fifo_count", fifo_count, sizeBefore);
    checkOutput("pending_hit", pending_hit, expHit);
    checkOutput("stall_req", stall_req, stallModel);

    if (reg_write && wt_addr != 0) dutRf[wt_addr] = wt_data;

    popNow = !live && (sizeBefore > 0);
    accept = lv && (sizeBefore < DEPTH);

    @(posedge clk);
    if (popNow) void'(expQ.pop_front());
    if (live) begin
      foreach (expQ[i]) if (expQ[i].rd == wrd) expQ[i].kill = 1'b1;
    end
    if (accept && lrd != 0) begin
      e.rd   = lrd;
      e.data = ldata;
      e.kill = live && (wrd == lrd);
      expQ.push_back(e);
    end
    if (sizeBefore == 0 || popNow) begin
      starveModel = 0;
      stallModel  = 1'b0;
    end else begin
      if (!headKilled && live && starveModel < LIMIT) starveModel++;
      if (starveModel == LIMIT) stallModel = 1'b1;
    end
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    reset       = 1'b0;
    wb_we       = 1'b0;
    wb_rd       = '0;
    wb_data     = '0;
    llu_valid   = 1'b0;
    llu_rd      = '0;
    llu_data    = '0;
    id_rs1_addr = '0;
    id_rs2_addr = '0;
    for (int i = 0; i < 32; i++) dutRf[i] = '0;

    repeat (2) @(posedge clk);
    #2;
    checkOutput("rst_fifo_count", fifo_count, 0);
    checkOutput("rst_llu_ready", llu_ready, 1);
    checkOutput("rst_stall_req", stall_req, 0);
    checkOutput("rst_reg_write", reg_write, 0);
    checkOutput("rst_pending_hit", pending_hit, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    idle();
    idle();

    // Single push drains one cycle later
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h1234);
    idle();
    idle();
    checkOutput("x5_value", dutRf[5], 32'h1234);

    // Two pushes under continuous WB traffic: full buffer, starvation stall
    applyStimulus(1'b1, 5'd10, 32'hA0, 1'b1, 5'd3, 32'h3333);
    applyStimulus(1'b1, 5'd11, 32'hA1, 1'b1, 5'd4, 32'h4444);
    applyStimulus(1'b1, 5'd12, 32'hA2, 1'b1, 5'd20, 32'h2020);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 5'(13 + i), 32'(i), 1'b0, 5'd0, 32'd0);
    checkOutput("stall_after_starve", stall_req, 1);
    repeat (3) idle();
    checkOutput("x3_value", dutRf[3], 32'h3333);
    checkOutput("x4_value", dutRf[4], 32'h4444);
    checkOutput("x20_refused", dutRf[20], 32'h0);
    checkOutput("stall_cleared", stall_req, 0);

    // Younger WB write kills a buffered result
    applyStimulus(1'b1, 5'd1, 32'h11, 1'b1, 5'd7, 32'h7777);
    applyStimulus(1'b1, 5'd7, 32'hAA, 1'b0, 5'd0, 32'd0);
    idle();
    idle();
    checkOutput("x7_value", dutRf[7], 32'hAA);

    // Same-cycle push and WB to the same register
    applyStimulus(1'b1, 5'd8, 32'h88, 1'b1, 5'd8, 32'hDEAD);
    idle();
    idle();
    checkOutput("x8_value", dutRf[8], 32'h88);

    // RAW hazard on an incoming and a buffered result, then x0 result
    applyStimulus(1'b1, 5'd1, 32'h1, 1'b1, 5'd9, 32'h9999, 5'd0, 5'd9);
    applyStimulus(1'b1, 5'd2, 32'h2, 1'b0, 5'd0, 32'd0, 5'd0, 5'd9);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd9);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd9);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hBAD, 5'd0, 5'd0);
    idle();
    idle();
    checkOutput("x9_value", dutRf[9], 32'h9999);

    // Full buffer with a pop and a push offer in the same cycle
    applyStimulus(1'b1, 5'd1, 32'h1, 1'b1, 5'd11, 32'hB1);
    applyStimulus(1'b1, 5'd2, 32'h2, 1'b1, 5'd12, 32'hC2);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd13, 32'hD3);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd13, 32'hD3);
    idle();
    idle();
    checkOutput("x11_value", dutRf[11], 32'hB1);
    checkOutput("x12_value", dutRf[12], 32'hC2);
    checkOutput("x13_value", dutRf[13], 32'hD3);

    // Random mix with a small register range to provoke kills and hits
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                    1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                    5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end
    repeat (4) idle();

    // Asynchronous reset with two results buffered
    applyStimulus(1'b1, 5'd1, 32'h1, 1'b1, 5'd21, 32'h2121);
    applyStimulus(1'b1, 5'd2, 32'h2, 1'b1, 5'd22, 32'h2222);
    wb_we     = 1'b0;
    llu_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async_fifo_count", fifo_count, 0);
    checkOutput("async_llu_ready", llu_ready, 1);
    checkOutput("async_stall_req", stall_req, 0);
    checkOutput("async_reg_write", reg_write, 0);
    expQ.delete();
    starveModel = 0;
    stallModel  = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b1;
    repeat (3) idle();
    checkOutput("x21_discarded", dutRf[21], 32'h0);
    checkOutput("x22_discarded", dutRf[22], 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
